// File: rtl/haz_pkg.sv
// Shared constants, stage indices and divider FSM state type for the pipeline hazard controller.
package haz_pkg;

    localparam int unsigned ST_IF  = 0;
    localparam int unsigned ST_ID  = 1;
    localparam int unsigned ST_EX  = 2;
    localparam int unsigned ST_MEM = 3;

    localparam logic [31:0] EXC_ERET = 32'h0000_000e;
    localparam logic [31:0] BEV_VEC  = 32'hbfc0_0380;
    localparam logic [11:0] EXC_OFF  = 12'h180;

    typedef enum logic [1:0] {
        DivIdle,
        DivWait,
        DivDone
    } div_state_e;

    // General exception vector: boot ROM when BEV is set, else offset from EBase.
    function automatic logic [31:0] exc_vector(input logic bev, input logic [19:0] ebase_hi);
        return bev ? BEV_VEC : {ebase_hi, EXC_OFF};
    endfunction

endpackage

// File: rtl/haz_div_fsm.sv
// Divider start/abort handshake; a finished divide waits in DivDone until EX advances so a
// stalled DIV is never issued twice.
module haz_div_fsm
    import haz_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ex_div_req,
    input  logic div_ready,
    input  logic xflush,
    input  logic ex_stall,
    output logic div_start,
    output logic div_abort,
    output logic div_busy
);

    div_state_e state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DivIdle;
        end else begin
            unique case (state)
                DivIdle: if (ex_div_req && !xflush) state <= DivWait;
                DivWait: begin
                    if (xflush) state <= DivIdle;
                    else if (div_ready) state <= DivDone;
                end
                DivDone: if (xflush || !ex_stall) state <= DivIdle;
                default: state <= DivIdle;
            endcase
        end
    end

    assign div_start = (state == DivIdle) && ex_div_req && !xflush;
    assign div_abort = (state != DivIdle) && xflush;
    assign div_busy  = ((state == DivIdle) && ex_div_req) || (state == DivWait);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// N-stage stall/flush controller: load-use scoreboard, divider handshake, exception redirect.
// Define HAZ_PERF_CNT_EN to add saturating stall-cause cycle counters.
module pipe_hazard_ctrl
    import haz_pkg::*;
#(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned LD_LAT = 2,
    parameter int unsigned EXC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_j_b_stall,
    input  logic              ex_rmem,
    input  logic [4:0]        ex_rt,
    input  logic              ex_div_req,
    input  logic              div_ready,
    output logic              div_start,
    output logic              div_abort,
    input  logic              ex_mult_stall,
    input  logic              stallreq_from_if,
    input  logic              stallreq_from_mem,
    input  logic [EXC_W-1:0]  mem_excepttype,
    input  logic [31:0]       mem_cp0_epc,
    input  logic              bev,
    input  logic [31:0]       ebase,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              redirect_valid,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]       perf_lw_cyc,
    output logic [31:0]       perf_div_cyc,
    output logic [31:0]       perf_mem_cyc,
`endif
    output logic [31:0]       redirect_pc
);

    localparam int unsigned SB_N = (LD_LAT > 1) ? LD_LAT - 1 : 1;

    logic                 exc_now;
    logic                 xflush;
    logic                 lwstall;
    logic                 gstall;
    logic                 id_hazard;
    logic                 div_busy;
    logic                 pend;
    logic [31:0]          pend_pc;
    logic [31:0]          exc_target;
    logic [SB_N-1:0]      sb_valid;
    logic [SB_N-1:0][4:0] sb_rd;

    logic unused_ebase;
    assign unused_ebase = ^ebase[11:0];

    // Scoreboard entry i tracks the instruction in stage MEM+i.
    function automatic int unsigned sb_stage(input int unsigned i);
        return (ST_MEM + i < NSTAGE) ? ST_MEM + i : NSTAGE - 1;
    endfunction

    assign exc_now = |mem_excepttype;
    assign xflush  = exc_now | pend;

    always_comb begin
        lwstall = 1'b0;
        if (ex_rmem && ex_rt != 5'd0 && (ex_rt == id_rs || ex_rt == id_rt)) lwstall = 1'b1;
        if (LD_LAT > 1) begin
            for (int i = 0; i < SB_N; i++) begin
                if (sb_valid[i] && sb_rd[i] != 5'd0 && (sb_rd[i] == id_rs || sb_rd[i] == id_rt)) begin
                    lwstall = 1'b1;
                end
            end
        end
    end

    haz_div_fsm u_div_fsm (
        .clk        (clk),
        .rst        (rst),
        .ex_div_req (ex_div_req),
        .div_ready  (div_ready),
        .xflush     (xflush),
        .ex_stall   (gstall),
        .div_start  (div_start),
        .div_abort  (div_abort),
        .div_busy   (div_busy)
    );

    assign gstall    = div_busy | stallreq_from_if | stallreq_from_mem | ex_mult_stall;
    assign id_hazard = lwstall | id_j_b_stall;

    always_comb begin
        stall = {NSTAGE{gstall}};
        flush = {NSTAGE{xflush}};
        stall[ST_IF] = stall[ST_IF] | id_hazard;
        stall[ST_ID] = stall[ST_ID] | id_hazard;
        // A bubble goes into EX only when the rest of the pipe is moving.
        flush[ST_EX] = flush[ST_EX] | (id_hazard & ~gstall);
        if (flush[ST_IF]) stall[ST_IF] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
            sb_rd    <= '0;
        end else begin
            if (flush[sb_stage(0)]) begin
                sb_valid[0] <= 1'b0;
                sb_rd[0]    <= 5'd0;
            end else if (!stall[ST_EX]) begin
                sb_valid[0] <= ex_rmem;
                sb_rd[0]    <= ex_rt;
            end
            for (int i = 1; i < SB_N; i++) begin
                if (flush[sb_stage(i)]) begin
                    sb_valid[i] <= 1'b0;
                    sb_rd[i]    <= 5'd0;
                end else if (!stall[ST_MEM]) begin
                    sb_valid[i] <= sb_valid[i-1];
                    sb_rd[i]    <= sb_rd[i-1];
                end
            end
        end
    end

    always_comb begin
        exc_target = (mem_excepttype == EXC_W'(EXC_ERET)) ? mem_cp0_epc
                                                          : exc_vector(bev, ebase[31:12]);
        redirect_valid = exc_now | pend;
        if (pend)         redirect_pc = pend_pc;
        else if (exc_now) redirect_pc = exc_target;
        else              redirect_pc = 32'd0;
    end

    // Fetch cannot accept a redirect while busy, so hold it until fetch frees up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            pend_pc <= 32'd0;
        end else if (exc_now && stallreq_from_if) begin
            pend    <= 1'b1;
            pend_pc <= exc_target;
        end else if (!stallreq_from_if) begin
            pend    <= 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lw_cyc  <= 32'd0;
            perf_div_cyc <= 32'd0;
            perf_mem_cyc <= 32'd0;
        end else begin
            if (lwstall && perf_lw_cyc != '1)             perf_lw_cyc  <= perf_lw_cyc + 32'd1;
            if (div_busy && perf_div_cyc != '1)           perf_div_cyc <= perf_div_cyc + 32'd1;
            if (stallreq_from_mem && perf_mem_cyc != '1)  perf_mem_cyc <= perf_mem_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline stall/flush controller for the MIPS core.
- Generalises the fixed 5-stage hazard unit in four ways:
  - N-stage stall/flush vectors.
  - Load-use scoreboard whose depth is set by LD_LAT.
  - Handshaked divider FSM that cannot restart a divide.
  - Exception redirect that is held while fetch is busy.
- Sits beside the datapath and drives every pipeline register's enable and clear.

Parameters:
- NSTAGE, 5: number of pipeline stages. Index 0=IF, 1=ID, 2=EX, 3=MEM, 4..NSTAGE-1=WB and later. NSTAGE must be at least 5.
- LD_LAT, 2: number of stages after ID whose load result cannot yet be forwarded. 2 means the load is checked in EX and in MEM.
- EXC_W, 32: width of the exception type field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- id_rs  in  5  ID source register
- id_rt  in  5  ID source register
- id_j_b_stall  in  1  branch operand not yet ready
- ex_rmem  in  1  EX instruction is a load
- ex_rt  in  5  EX load destination register
- ex_div_req  in  1  EX instruction is DIV or DIVU
- div_ready  in  1  divider result valid
- div_start  out  1  divider start pulse
- div_abort  out  1  cancels an in-flight divide
- ex_mult_stall  in  1  multiplier busy
- stallreq_from_if  in  1  instruction fetch busy
- stallreq_from_mem  in  1  data memory busy
- mem_excepttype  in  EXC_W  exception code, 0 means none
- mem_cp0_epc  in  32  EPC value
- bev  in  1  CP0 Status.BEV
- ebase  in  32  CP0 EBase
- stall  out  NSTAGE  per-stage hold
- flush  out  NSTAGE  per-stage clear
- redirect_valid  out  1  take redirect_pc
- redirect_pc  out  32  exception or ERET target

Behaviour:
- Reset (rst=1, asynchronous): div FSM goes to IDLE, scoreboard is cleared, redirect-pending is cleared. All outputs are 0 during and after reset until the inputs change.
- Load scoreboard:
  - Valid/rd shift register with LD_LAT-1 entries.
  - Entry 0 loads {ex_rmem, ex_rt} whenever stall[2]=0.
  - Entries shift whenever stall[3]=0.
  - Entries are cleared by flush of the stage they represent.
  - lwstall asserts when id_rs or id_rt matches ex_rt (with ex_rmem set), or matches any valid entry.
  - Register 0 never matches.
- Divider FSM, states IDLE, WAIT, DONE:
  - IDLE & ex_div_req & !xflush: div_start=1 for exactly one cycle, next state WAIT.
  - WAIT: div_start=0; when div_ready, next state DONE.
  - DONE: leaves to IDLE when stall[2]=0. While DONE, ex_div_req is ignored, so a stalled divide is never restarted.
  - div_busy = (IDLE & ex_div_req) | WAIT.
  - xflush in WAIT or DONE: div_abort=1 for one cycle, next state IDLE.
- Stall composition:
  - gstall = div_busy | stallreq_from_if | stallreq_from_mem | ex_mult_stall.
  - stall[k] = gstall for all k.
  - stall[0] and stall[1] additionally OR in (lwstall | id_j_b_stall).
  - stall[0] is forced to 0 whenever flush[0]=1.
- Flush composition:
  - xflush = (mem_excepttype != 0) | pend.
  - flush[k] = xflush for all k.
  - flush[2] additionally = (lwstall | id_j_b_stall) & !gstall, which inserts a bubble.
- Redirect:
  - target = mem_cp0_epc when excepttype == EXC_ERET.
  - Otherwise target = bev ? 0xBFC00380 : {ebase[31:12], 12'h180}.
  - If the exception occurs while stallreq_from_if=1: set pend and latch pend_pc.
  - pend clears on the first cycle with stallreq_from_if=0.
  - redirect_valid = (mem_excepttype != 0) | pend.
  - redirect_pc = pend ? pend_pc : target; it is 0 when redirect_valid=0.
  - A new exception while pend is set overrides pend_pc (newest wins).
- Simultaneous events:
  - Exception together with lwstall: flush wins.
  - Exception together with div_ready: abort wins, state goes to IDLE.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - Three 32-bit saturating counters: perf_lw_cyc, perf_div_cyc, perf_mem_cyc.
  - Each increments on every cycle its cause is asserted (lwstall, div_busy|WAIT, stallreq_from_mem).
  - Cleared by rst; exposed as extra output ports.
- HAZ_PERF_CNT_EN undefined: the ports and logic are absent.

Decomposition:
- Package haz_pkg holds:
  - Stage indices: ST_IF=0, ST_ID=1, ST_EX=2, ST_MEM=3.
  - EXC_ERET code.
  - Vector constants: BEV_VEC=0xBFC00380, EXC_OFF=12'h180.
  - The div FSM state enum.
- One sub-module, haz_div_fsm, owns the divider handshake and the div_abort logic.

Test Plan:
- Load-use: ex_rmem=1, ex_rt=5, id_rs=5 -> stall[1:0]=11, flush[2]=1 for 1 cycle, then for 1 more cycle via the scoreboard (LD_LAT=2). id_rs=0 -> no stall.
- Divide: ex_div_req=1, div_ready rises after 10 cycles -> div_start high for exactly 1 cycle, stall=all ones for 11 cycles. With stallreq_from_mem held through DONE -> no second div_start.
- Exception: mem_excepttype=1, bev=0, ebase=0x80001000 -> redirect_pc=0x80001180, flush=all ones, stall[0]=0.
- ERET: excepttype=EXC_ERET, epc=0x8000_0040 -> redirect_pc=0x80000040 in the same cycle.
- Pending redirect: exception while stallreq_from_if=1 for 3 cycles -> redirect_valid held for 4 cycles with a stable pc, then deasserts.
- Abort: exception during div WAIT -> div_abort pulses once, next request produces a fresh div_start.
